multicycle_ctrl: RTL and testbench

- Parametrised multi-cycle sequencer for the Pillar core. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives pulse-style enables into the PC, operand latches and writeback registers.
- Improves on the fixed five-count controller:
  - valid/ready memory handshake with wait states and a timeout;
  - real load/store data phases;
  - HALT and TRAP states;
  - retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle instruction sequencer for the Pillar core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, runs a
// valid/ready memory handshake with a bounded wait, and parks in HALT or
// TRAP until reset. Every output is a register; the output process below
// computes the value each register takes at the coming edge.
module multicycle_ctrl #(
  parameter int XLEN     = 32,
  parameter int ITYPE_W  = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [2:0]         stage_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic [XLEN-1:0]    mem_wdata_o,
  input  logic [XLEN-1:0]    mem_rdata_i,
  input  logic               mem_ready_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               pc_readin_o,
  output logic [XLEN-1:0]    ir_o,
  input  logic [ITYPE_W-1:0] itype_i,
  input  logic [XLEN-1:0]    alu_res_i,
  input  logic [XLEN-1:0]    store_data_i,
  output logic               readin_a_o,
  output logic               readin_b_o,
  output logic               readin_pass_o,
  output logic [XLEN-1:0]    load_data_o,
  output logic               wd_q_readin_o,
  output logic               wd_q_o,
  output logic               halted_o,
  output logic               trap_o,
  output logic [1:0]         trap_cause_o,
  output logic [CNT_W-1:0]   instret_o
);

  // Decoder itype codes shared with the rest of the core; anything else is illegal.
  localparam logic [ITYPE_W-1:0] IT_RTYPE = ITYPE_W'(1);
  localparam logic [ITYPE_W-1:0] IT_ITYPE = ITYPE_W'(2);
  localparam logic [ITYPE_W-1:0] IT_STYPE = ITYPE_W'(3);
  localparam logic [ITYPE_W-1:0] IT_BTYPE = ITYPE_W'(4);
  localparam logic [ITYPE_W-1:0] IT_UTYPE = ITYPE_W'(5);
  localparam logic [ITYPE_W-1:0] IT_LTYPE = ITYPE_W'(6);
  localparam logic [ITYPE_W-1:0] IT_HOLD  = ITYPE_W'(7);

  // The timeout fires on the edge where the wait count would reach MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_FETCH   = 2'd2;
  localparam logic [1:0] CAUSE_DATA    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } stage_e;

  stage_e             state_q, state_d;
  logic [7:0]         waitCnt_q, waitCnt_d;
  logic [ITYPE_W-1:0] itype_q, itype_d;
  logic               memReq_q, memReq_d;
  logic               memWe_q, memWe_d;
  logic [XLEN-1:0]    memAddr_q, memAddr_d;
  logic [XLEN-1:0]    memWdata_q, memWdata_d;
  logic               pcReadin_q, pcReadin_d;
  logic [XLEN-1:0]    ir_q, ir_d;
  logic               readinA_q, readinA_d;
  logic               readinB_q, readinB_d;
  logic               readinPass_q, readinPass_d;
  logic [XLEN-1:0]    loadData_q, loadData_d;
  logic               wdqReadin_q, wdqReadin_d;
  logic               wdq_q, wdq_d;
  logic               halted_q, halted_d;
  logic               trap_q, trap_d;
  logic [1:0]         trapCause_q, trapCause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  function automatic logic usesBothOperands(input logic [ITYPE_W-1:0] t);
    return (t == IT_RTYPE) || (t == IT_ITYPE) || (t == IT_LTYPE) ||
           (t == IT_STYPE) || (t == IT_BTYPE);
  endfunction

  function automatic logic usesPass(input logic [ITYPE_W-1:0] t);
    return (t == IT_STYPE) || (t == IT_BTYPE);
  endfunction

  function automatic logic isMemOp(input logic [ITYPE_W-1:0] t);
    return (t == IT_STYPE) || (t == IT_LTYPE);
  endfunction

  function automatic logic capturesWb(input logic [ITYPE_W-1:0] t);
    return (t == IT_RTYPE) || (t == IT_ITYPE) || (t == IT_STYPE) ||
           (t == IT_UTYPE) || (t == IT_LTYPE);
  endfunction

  function automatic logic writesReg(input logic [ITYPE_W-1:0] t);
    return (t == IT_RTYPE) || (t == IT_ITYPE) || (t == IT_UTYPE) ||
           (t == IT_LTYPE);
  endfunction

  // State and output registers; reset wins over everything, even mid-request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      waitCnt_q    <= '0;
      itype_q      <= '0;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      pcReadin_q   <= 1'b1;
      ir_q         <= '0;
      readinA_q    <= 1'b0;
      readinB_q    <= 1'b0;
      readinPass_q <= 1'b0;
      loadData_q   <= '0;
      wdqReadin_q  <= 1'b0;
      wdq_q        <= 1'b0;
      halted_q     <= 1'b0;
      trap_q       <= 1'b0;
      trapCause_q  <= 2'd0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      itype_q      <= itype_d;
      memReq_q     <= memReq_d;
      memWe_q      <= memWe_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      pcReadin_q   <= pcReadin_d;
      ir_q         <= ir_d;
      readinA_q    <= readinA_d;
      readinB_q    <= readinB_d;
      readinPass_q <= readinPass_d;
      loadData_q   <= loadData_d;
      wdqReadin_q  <= wdqReadin_d;
      wdq_q        <= wdq_d;
      halted_q     <= halted_d;
      trap_q       <= trap_d;
      trapCause_q  <= trapCause_d;
      instret_q    <= instret_d;
    end
  end

  // Next-state selection; ready is only looked at while a request is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i)                 state_d = S_DECODE;
        else if (waitCnt_q == WAIT_LAST) state_d = S_TRAP;
      end
      S_DECODE: begin
        if (itype_i == IT_HOLD)                                 state_d = S_HALT;
        else if (usesBothOperands(itype_i) || itype_i == IT_UTYPE) state_d = S_EXEC;
        else                                                    state_d = S_TRAP;
      end
      S_EXEC:   state_d = S_MEM;
      S_MEM: begin
        if (!isMemOp(itype_q))           state_d = S_WB;
        else if (mem_ready_i)            state_d = S_WB;
        else if (waitCnt_q == WAIT_LAST) state_d = S_TRAP;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  // Register values for the coming edge; wd_q_readin_o stays up for the whole
  // MEM phase of S/L types so it is high in the final cycle whatever the wait.
  always_comb begin
    waitCnt_d    = waitCnt_q;
    itype_d      = itype_q;
    memReq_d     = memReq_q;
    memWe_d      = memWe_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    pcReadin_d   = pcReadin_q;
    ir_d         = ir_q;
    readinA_d    = readinA_q;
    readinB_d    = readinB_q;
    readinPass_d = readinPass_q;
    loadData_d   = loadData_q;
    wdqReadin_d  = wdqReadin_q;
    wdq_d        = wdq_q;
    halted_d     = halted_q;
    trap_d       = trap_q;
    trapCause_d  = trapCause_q;
    instret_d    = instret_q;
    case (state_q)
      S_IDLE, S_WB: begin
        memReq_d   = 1'b1;
        memWe_d    = 1'b0;
        memAddr_d  = pc_i;
        pcReadin_d = 1'b0;
        wdq_d      = 1'b0;
        waitCnt_d  = '0;
      end
      S_FETCH: begin
        if (mem_ready_i) begin
          ir_d     = mem_rdata_i;
          memReq_d = 1'b0;
        end else if (waitCnt_q == WAIT_LAST) begin
          memReq_d    = 1'b0;
          trap_d      = 1'b1;
          trapCause_d = CAUSE_FETCH;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        itype_d      = itype_i;
        readinA_d    = 1'b0;
        readinB_d    = 1'b0;
        readinPass_d = 1'b0;
        if (itype_i == IT_HOLD) begin
          halted_d = 1'b1;
        end else if (usesBothOperands(itype_i)) begin
          readinA_d    = 1'b1;
          readinB_d    = 1'b1;
          readinPass_d = usesPass(itype_i);
        end else if (itype_i == IT_UTYPE) begin
          readinA_d = 1'b1;
        end else begin
          trap_d      = 1'b1;
          trapCause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        readinA_d    = 1'b0;
        readinB_d    = 1'b0;
        readinPass_d = 1'b0;
        waitCnt_d    = '0;
        wdqReadin_d  = capturesWb(itype_q);
        if (itype_q == IT_STYPE) begin
          memReq_d   = 1'b1;
          memWe_d    = 1'b1;
          memAddr_d  = alu_res_i;
          memWdata_d = store_data_i;
        end else if (itype_q == IT_LTYPE) begin
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = alu_res_i;
        end
      end
      S_MEM: begin
        if (!isMemOp(itype_q) || mem_ready_i) begin
          if (isMemOp(itype_q) && itype_q == IT_LTYPE) loadData_d = mem_rdata_i;
          memReq_d    = 1'b0;
          memWe_d     = 1'b0;
          wdqReadin_d = 1'b0;
          wdq_d       = writesReg(itype_q);
          pcReadin_d  = 1'b1;
          instret_d   = instret_q + CNT_W'(1);
        end else if (waitCnt_q == WAIT_LAST) begin
          memReq_d    = 1'b0;
          memWe_d     = 1'b0;
          wdqReadin_d = 1'b0;
          trap_d      = 1'b1;
          trapCause_d = CAUSE_DATA;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign stage_o       = state_q;
  assign mem_req_o     = memReq_q;
  assign mem_we_o      = memWe_q;
  assign mem_addr_o    = memAddr_q;
  assign mem_wdata_o   = memWdata_q;
  assign pc_readin_o   = pcReadin_q;
  assign ir_o          = ir_q;
  assign readin_a_o    = readinA_q;
  assign readin_b_o    = readinB_q;
  assign readin_pass_o = readinPass_q;
  assign load_data_o   = loadData_q;
  assign wd_q_readin_o = wdqReadin_q;
  assign wd_q_o        = wdq_q;
  assign halted_o      = halted_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = trapCause_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: builds a cycle-by-cycle trace of inputs and expected
// outputs from instruction-level descriptions, then replays it against the DUT.
module tb_multicycle_ctrl;

  localparam int XLEN     = 32;
  localparam int ITYPE_W  = 5;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 32;

  localparam logic [4:0] IT_R = 5'd1, IT_I = 5'd2, IT_S = 5'd3, IT_B = 5'd4;
  localparam logic [4:0] IT_U = 5'd5, IT_L = 5'd6, IT_HOLD = 5'd7;

  localparam int T_RESET = 1, T_R_EXEC = 2, T_R_WB = 3, T_S_MEM = 4;
  localparam int T_L_WB = 5, T_F_TRAP = 6, T_HALT = 7;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] stage_o;
  logic mem_req_o, mem_we_o, mem_ready_i, pc_readin_o;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_i, ir_o;
  logic [ITYPE_W-1:0] itype_i;
  logic [XLEN-1:0] alu_res_i, store_data_i, load_data_o;
  logic readin_a_o, readin_b_o, readin_pass_o, wd_q_readin_o, wd_q_o;
  logic halted_o, trap_o;
  logic [1:0] trap_cause_o;
  logic [CNT_W-1:0] instret_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.XLEN(XLEN), .ITYPE_W(ITYPE_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stage_o(stage_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .pc_i(pc_i),
    .pc_readin_o(pc_readin_o), .ir_o(ir_o), .itype_i(itype_i),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i), .readin_a_o(readin_a_o),
    .readin_b_o(readin_b_o), .readin_pass_o(readin_pass_o),
    .load_data_o(load_data_o), .wd_q_readin_o(wd_q_readin_o), .wd_q_o(wd_q_o),
    .halted_o(halted_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
    .instret_o(instret_o)
  );

  typedef struct {
    logic rst; logic ready; logic [31:0] pc, rdata, alu, sd; logic [4:0] itype;
    logic [2:0] stage; logic req, we; logic [31:0] addr, wdata; logic pcrd;
    logic [31:0] ir; logic a, b, pass; logic [31:0] load; logic wdrd, wdq;
    logic halted, trap; logic [1:0] cause; logic [31:0] instret; int tag;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  logic nRst, nReady;
  logic [31:0] nPc, nRdata, nAlu, nSd;
  logic [4:0] nItype = 5'd0;
  int checks = 0;
  int errors = 0;

  function automatic bit bothOps(input logic [4:0] t);
    return t == IT_R || t == IT_I || t == IT_L || t == IT_S || t == IT_B;
  endfunction
  function automatic bit memOp(input logic [4:0] t);
    return t == IT_S || t == IT_L;
  endfunction
  function automatic bit wbCapture(input logic [4:0] t);
    return t == IT_R || t == IT_I || t == IT_S || t == IT_U || t == IT_L;
  endfunction
  function automatic bit regWrite(input logic [4:0] t);
    return t == IT_R || t == IT_I || t == IT_U || t == IT_L;
  endfunction

  task automatic randIns();
    nRst = 1'b1; nReady = 1'($urandom_range(0, 1));
    nPc = $urandom; nRdata = $urandom; nAlu = $urandom; nSd = $urandom;
  endtask

  task automatic pushCycle(input int tag);
    cyc_t e;
    e = cur;
    e.rst = nRst; e.ready = nReady; e.pc = nPc; e.rdata = nRdata;
    e.alu = nAlu; e.sd = nSd; e.itype = nItype; e.tag = tag;
    plan.push_back(e);
  endtask

  task automatic planReset(input int n);
    for (int k = 0; k < n; k++) begin
      randIns(); nRst = 1'b0;
      cur.stage = 3'd0; cur.req = 0; cur.we = 0; cur.addr = 0; cur.wdata = 0;
      cur.pcrd = 1; cur.ir = 0; cur.a = 0; cur.b = 0; cur.pass = 0; cur.load = 0;
      cur.wdrd = 0; cur.wdq = 0; cur.halted = 0; cur.trap = 0; cur.cause = 0;
      cur.instret = 0;
      pushCycle(T_RESET);
    end
  endtask

  task automatic planHold(input int n, input int tag);
    for (int k = 0; k < n; k++) begin
      randIns(); pushCycle(tag);
    end
  endtask

  // One instruction from FETCH entry; term=1 when it ends in HALT or TRAP,
  // and it returns early (term=0) after abortAt data wait cycles.
  task automatic planInstr(input logic [4:0] it, input int fw, input int dw,
                           input logic [31:0] pc, input logic [31:0] irv,
                           input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] ldata, input int abortAt,
                           input int scen, output bit term);
    term = 0;
    nItype = it;
    randIns(); nPc = pc;
    cur.stage = 3'd1; cur.req = 1; cur.we = 0; cur.addr = pc; cur.pcrd = 0; cur.wdq = 0;
    pushCycle(0);
    for (int w = 0; w < fw && w < MAX_WAIT; w++) begin
      randIns(); nReady = 0;
      if (w == MAX_WAIT - 1) begin
        cur.stage = 3'd7; cur.req = 0; cur.trap = 1; cur.cause = 2'd2;
        pushCycle(scen == 4 ? T_F_TRAP : 0);
        term = 1;
        return;
      end
      pushCycle(0);
    end
    randIns(); nReady = 1; nRdata = irv;
    cur.stage = 3'd2; cur.req = 0; cur.ir = irv;
    pushCycle(0);
    randIns();
    if (it == IT_HOLD) begin
      cur.stage = 3'd6; cur.halted = 1;
      pushCycle(scen == 5 ? T_HALT : 0);
      term = 1;
      return;
    end
    if (!bothOps(it) && it != IT_U) begin
      cur.stage = 3'd7; cur.trap = 1; cur.cause = 2'd1;
      pushCycle(0);
      term = 1;
      return;
    end
    cur.stage = 3'd3; cur.a = 1; cur.b = bothOps(it); cur.pass = (it == IT_S || it == IT_B);
    pushCycle(scen == 1 ? T_R_EXEC : 0);
    randIns(); nAlu = alu; nSd = sd;
    cur.stage = 3'd4; cur.a = 0; cur.b = 0; cur.pass = 0; cur.wdrd = wbCapture(it);
    if (memOp(it)) begin
      cur.req = 1; cur.we = (it == IT_S); cur.addr = alu;
      if (it == IT_S) cur.wdata = sd;
    end
    pushCycle(scen == 2 ? T_S_MEM : 0);
    if (memOp(it)) begin
      for (int w = 0; w < dw && w < MAX_WAIT; w++) begin
        if (w == abortAt) return;
        randIns(); nReady = 0;
        if (w == MAX_WAIT - 1) begin
          cur.stage = 3'd7; cur.req = 0; cur.we = 0; cur.wdrd = 0;
          cur.trap = 1; cur.cause = 2'd3;
          pushCycle(0);
          term = 1;
          return;
        end
        pushCycle(scen == 2 ? T_S_MEM : 0);
      end
      randIns(); nReady = 1; nRdata = ldata;
      if (it == IT_L) cur.load = ldata;
    end else begin
      randIns();
    end
    cur.stage = 3'd5; cur.req = 0; cur.we = 0; cur.wdrd = 0;
    cur.wdq = regWrite(it); cur.pcrd = 1; cur.instret = cur.instret + 1;
    pushCycle(scen == 1 ? T_R_WB : (scen == 3 ? T_L_WB : 0));
  endtask

  task automatic applyStimulus(input cyc_t e);
    reset = e.rst; mem_ready_i = e.ready; pc_i = e.pc; mem_rdata_i = e.rdata;
    alu_res_i = e.alu; store_data_i = e.sd; itype_i = e.itype;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input cyc_t e, input int i);
    check("stage", 32'(stage_o), 32'(e.stage), i);
    check("mem_req", 32'(mem_req_o), 32'(e.req), i);
    check("mem_we", 32'(mem_we_o), 32'(e.we), i);
    check("mem_addr", mem_addr_o, e.addr, i);
    check("mem_wdata", mem_wdata_o, e.wdata, i);
    check("pc_readin", 32'(pc_readin_o), 32'(e.pcrd), i);
    check("ir", ir_o, e.ir, i);
    check("readin_a", 32'(readin_a_o), 32'(e.a), i);
    check("readin_b", 32'(readin_b_o), 32'(e.b), i);
    check("readin_pass", 32'(readin_pass_o), 32'(e.pass), i);
    check("load_data", load_data_o, e.load, i);
    check("wd_q_readin", 32'(wd_q_readin_o), 32'(e.wdrd), i);
    check("wd_q", 32'(wd_q_o), 32'(e.wdq), i);
    check("halted", 32'(halted_o), 32'(e.halted), i);
    check("trap", 32'(trap_o), 32'(e.trap), i);
    check("trap_cause", 32'(trap_cause_o), 32'(e.cause), i);
    check("instret", instret_o, e.instret, i);
    case (e.tag)
      T_RESET: begin
        check("lit_reset_stage", 32'(stage_o), 32'd0, i);
        check("lit_reset_pcrd", 32'(pc_readin_o), 32'd1, i);
        check("lit_reset_instret", instret_o, 32'd0, i);
        check("lit_reset_req", 32'(mem_req_o), 32'd0, i);
      end
      T_R_EXEC: begin
        check("lit_r_stage", 32'(stage_o), 32'd3, i);
        check("lit_r_ir", ir_o, 32'h00B50533, i);
        check("lit_r_addr", mem_addr_o, 32'h10, i);
        check("lit_r_ab", {30'd0, readin_a_o, readin_b_o}, 32'd3, i);
        check("lit_r_pass", 32'(readin_pass_o), 32'd0, i);
      end
      T_R_WB: begin
        check("lit_rwb_stage", 32'(stage_o), 32'd5, i);
        check("lit_rwb_wdq", 32'(wd_q_o), 32'd1, i);
        check("lit_rwb_pcrd", 32'(pc_readin_o), 32'd1, i);
        check("lit_rwb_instret", instret_o, 32'd1, i);
      end
      T_S_MEM: begin
        check("lit_s_we", 32'(mem_we_o), 32'd1, i);
        check("lit_s_addr", mem_addr_o, 32'h200, i);
        check("lit_s_wdata", mem_wdata_o, 32'hDEADBEEF, i);
        check("lit_s_wdq", 32'(wd_q_o), 32'd0, i);
      end
      T_L_WB: begin
        check("lit_l_load", load_data_o, 32'h12345678, i);
        check("lit_l_wdq", 32'(wd_q_o), 32'd1, i);
      end
      T_F_TRAP: begin
        check("lit_ftrap_stage", 32'(stage_o), 32'd7, i);
        check("lit_ftrap_cause", 32'(trap_cause_o), 32'd2, i);
        check("lit_ftrap_req", 32'(mem_req_o), 32'd0, i);
      end
      T_HALT: begin
        check("lit_halt_stage", 32'(stage_o), 32'd6, i);
        check("lit_halt_flag", 32'(halted_o), 32'd1, i);
      end
      default: begin
      end
    endcase
  endtask

  function automatic int pickWait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return $urandom_range(0, 2);
    if (r < 15) return MAX_WAIT - 1;
    if (r < 18) return $urandom_range(3, MAX_WAIT - 2);
    return MAX_WAIT;
  endfunction

  function automatic logic [4:0] pickType();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return IT_HOLD;
    if (r == 1) begin
      r = $urandom_range(0, 24);
      return (r == 0) ? 5'd0 : 5'(7 + r);
    end
    return 5'($urandom_range(1, 6));
  endfunction

  initial begin
    bit term;
    planReset(3);
    planInstr(IT_R, 0, 0, 32'h10, 32'h00B50533, $urandom, $urandom, $urandom, -1, 1, term);
    planInstr(IT_S, 0, 3, $urandom, $urandom, 32'h200, 32'hDEADBEEF, $urandom, -1, 2, term);
    planInstr(IT_L, 1, 2, $urandom, $urandom, $urandom, $urandom, 32'h12345678, -1, 3, term);
    planInstr(IT_HOLD, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 5, term);
    planHold(3, T_HALT);
    planReset(2);
    planInstr(IT_L, 0, 8, $urandom, $urandom, $urandom, $urandom, $urandom, 2, 0, term);
    planReset(1);
    planInstr(IT_R, MAX_WAIT, 0, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 4, term);
    planHold(3, T_F_TRAP);
    planReset(2);
    for (int k = 0; k < 80; k++) begin
      planInstr(pickType(), pickWait(), pickWait(), $urandom, $urandom, $urandom,
                $urandom, $urandom, -1, 0, term);
      if (term) begin
        planHold(2, 0);
        planReset(2);
      end
    end

    applyStimulus(plan[0]);
    for (int i = 0; i < plan.size(); i++) begin
      @(negedge clk);
      checkOutput(plan[i], i);
      if (i + 1 < plan.size()) applyStimulus(plan[i + 1]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
